// File: rtl/serial_rtype_ctrl.sv
// rtl/serial_rtype_ctrl.sv - lane-parametrised serial R-type control unit
//
// Purpose: deserialises a 32-bit instruction LANES bits per beat, decodes and
// legality-checks R-type encodings, then sequences the serial execute phase
// and the PC-advance / retire strobes.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   ins_data/ins_valid   instruction slice and its valid flag
//   ins_ready            beat accepted this cycle (FETCH only)
//   hold                 freezes EXEC for the current cycle
//   insbuffer            assembled instruction
//   alu_cont/rs1/rs2/rd  decoded fields, registered in DECODE
//   rs_en/alu_en/rd_en   serial operand / ALU / writeback enables
//   pcload_en            one-cycle PC advance strobe (COMMIT)
//   illegal/done         one-cycle illegal or retire strobe (COMMIT)
//   busy                 state is not FETCH
module serial_rtype_ctrl #(
   parameter int LANES  = 1,
   parameter int DATA_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LANES-1:0] ins_data,
   input  logic             ins_valid,
   output logic             ins_ready,
   input  logic             hold,
   output logic [31:0]      insbuffer,
   output logic [3:0]       alu_cont,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic             rs_en,
   output logic             alu_en,
   output logic             rd_en,
   output logic             pcload_en,
   output logic             illegal,
   output logic             done,
   output logic             busy
);

   localparam int FETCH_BEATS = 32 / LANES;
   localparam int EXEC_CYCLES = DATA_W / LANES;
   localparam int CNT_MAX     = (FETCH_BEATS > EXEC_CYCLES) ? FETCH_BEATS : EXEC_CYCLES;
   localparam int CNT_W       = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      EXEC   = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_ins;
   logic [31:0]       w_ins_shift;
   logic [3:0]        r_alu_cont;
   logic [4:0]        r_rs1;
   logic [4:0]        r_rs2;
   logic [4:0]        r_rd;
   logic              r_illegal;

   logic              w_beat;
   logic              w_cnt_inc;
   logic              w_cnt_clr;
   logic              w_decode;
   logic              w_legal;
   logic              w_ready;
   logic              w_step;
   logic              w_rd_en;
   logic              w_pcload;
   logic              w_illegal;
   logic              w_done;
   logic              w_busy;

   // New slice enters at the top so the first beat ends up in the low bits.
   generate
      if (LANES == 32) begin : g_full
         assign w_ins_shift = ins_data;
      end else begin : g_part
         assign w_ins_shift = {ins_data, r_ins[31:LANES]};
      end
   endgenerate

   // Only the two base R-type funct7 values; the alternate form exists only
   // for sub (000) and sra (101).
   always_comb begin
      w_legal = 1'b0;
      if (r_ins[6:0] == 7'b0110011) begin
         if (r_ins[31:25] == 7'b0000000) begin
            w_legal = 1'b1;
         end else if (r_ins[31:25] == 7'b0100000) begin
            w_legal = (r_ins[14:12] == 3'b000) || (r_ins[14:12] == 3'b101);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_beat      = 1'b0;
      w_cnt_inc   = 1'b0;
      w_cnt_clr   = 1'b0;
      w_decode    = 1'b0;
      w_ready     = 1'b0;
      w_step      = 1'b0;
      w_rd_en     = 1'b0;
      w_pcload    = 1'b0;
      w_illegal   = 1'b0;
      w_done      = 1'b0;
      w_busy      = 1'b1;
      unique case (r_state)
         FETCH: begin
            w_busy  = 1'b0;
            w_ready = reset;
            if (ins_valid) begin
               w_beat = 1'b1;
               if (r_cnt == CNT_W'(FETCH_BEATS - 1)) begin
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = DECODE;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         DECODE: begin
            w_decode    = 1'b1;
            w_state_nxt = w_legal ? EXEC : COMMIT;
         end
         EXEC: begin
            if (!hold) begin
               w_step  = 1'b1;
               w_rd_en = (r_rd != 5'd0);
               if (r_cnt == CNT_W'(EXEC_CYCLES - 1)) begin
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = COMMIT;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         COMMIT: begin
            w_pcload    = 1'b1;
            w_illegal   = r_illegal;
            w_done      = !r_illegal;
            w_state_nxt = FETCH;
         end
         default: w_state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_ins      <= '0;
         r_alu_cont <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_illegal  <= 1'b0;
      end else begin
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_beat) begin
            r_ins <= w_ins_shift;
         end
         if (w_decode) begin
            r_alu_cont <= {r_ins[30], r_ins[14:12]};
            r_rs1      <= r_ins[19:15];
            r_rs2      <= r_ins[24:20];
            r_rd       <= r_ins[11:7];
            r_illegal  <= !w_legal;
         end
      end
   end

   assign insbuffer = r_ins;
   assign alu_cont  = r_alu_cont;
   assign rs1       = r_rs1;
   assign rs2       = r_rs2;
   assign rd        = r_rd;
   assign ins_ready = w_ready;
   assign rs_en     = w_step;
   assign alu_en    = w_step;
   assign rd_en     = w_rd_en;
   assign pcload_en = w_pcload;
   assign illegal   = w_illegal;
   assign done      = w_done;
   assign busy      = w_busy;

endmodule

// File: tb/tb_serial_rtype_ctrl.sv
// tb/tb_serial_rtype_ctrl.sv - scoreboard bench for serial_rtype_ctrl at LANES=1 and LANES=4
module tb_serial_rtype_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // LANES=1 instance
   logic [0:0]  d1_data = '0;
   logic        d1_valid = 1'b0, d1_hold = 1'b0;
   logic        d1_ready, d1_rs_en, d1_alu_en, d1_rd_en, d1_pc, d1_ill, d1_done, d1_busy;
   logic [31:0] d1_ins;
   logic [3:0]  d1_alu;
   logic [4:0]  d1_rs1, d1_rs2, d1_rd;

   // LANES=4 instance
   logic [3:0]  d4_data = '0;
   logic        d4_valid = 1'b0, d4_hold = 1'b0;
   logic        d4_ready, d4_rs_en, d4_alu_en, d4_rd_en, d4_pc, d4_ill, d4_done, d4_busy;
   logic [31:0] d4_ins;
   logic [3:0]  d4_alu;
   logic [4:0]  d4_rs1, d4_rs2, d4_rd;

   serial_rtype_ctrl #(.LANES(1), .DATA_W(32)) u_dut1 (
      .clk(clk), .reset(reset), .ins_data(d1_data), .ins_valid(d1_valid),
      .ins_ready(d1_ready), .hold(d1_hold), .insbuffer(d1_ins), .alu_cont(d1_alu),
      .rs1(d1_rs1), .rs2(d1_rs2), .rd(d1_rd), .rs_en(d1_rs_en), .alu_en(d1_alu_en),
      .rd_en(d1_rd_en), .pcload_en(d1_pc), .illegal(d1_ill), .done(d1_done), .busy(d1_busy)
   );

   serial_rtype_ctrl #(.LANES(4), .DATA_W(32)) u_dut4 (
      .clk(clk), .reset(reset), .ins_data(d4_data), .ins_valid(d4_valid),
      .ins_ready(d4_ready), .hold(d4_hold), .insbuffer(d4_ins), .alu_cont(d4_alu),
      .rs1(d4_rs1), .rs2(d4_rs2), .rd(d4_rd), .rs_en(d4_rs_en), .alu_en(d4_alu_en),
      .rd_en(d4_rd_en), .pcload_en(d4_pc), .illegal(d4_ill), .done(d4_done), .busy(d4_busy)
   );

   // Observation mux: sel_g=1 selects the LANES=4 instance
   logic        sel_g = 1'b0;
   logic        o_ready, o_rs_en, o_alu_en, o_rd_en, o_pc, o_ill, o_done, o_busy;
   logic [31:0] o_ins;
   logic [3:0]  o_alu;
   logic [4:0]  o_rs1, o_rs2, o_rd;
   assign o_ready  = sel_g ? d4_ready  : d1_ready;
   assign o_rs_en  = sel_g ? d4_rs_en  : d1_rs_en;
   assign o_alu_en = sel_g ? d4_alu_en : d1_alu_en;
   assign o_rd_en  = sel_g ? d4_rd_en  : d1_rd_en;
   assign o_pc     = sel_g ? d4_pc     : d1_pc;
   assign o_ill    = sel_g ? d4_ill    : d1_ill;
   assign o_done   = sel_g ? d4_done   : d1_done;
   assign o_busy   = sel_g ? d4_busy   : d1_busy;
   assign o_ins    = sel_g ? d4_ins    : d1_ins;
   assign o_alu    = sel_g ? d4_alu    : d1_alu;
   assign o_rs1    = sel_g ? d4_rs1    : d1_rs1;
   assign o_rs2    = sel_g ? d4_rs2    : d1_rs2;
   assign o_rd     = sel_g ? d4_rd     : d1_rd;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] ins;
      logic [3:0]  alu;
      logic [4:0]  rs1, rs2, rd;
      logic        ill;
      int          rsc, rdc, total;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rdd);
      return {f7, r2, r1, f3, rdd, 7'b0110011};
   endfunction

   task automatic check_reset_state(input string tag);
      chk({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
      chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      chk({tag, "_ins"}, o_ins, 32'd0);
      chk({tag, "_fields"}, {13'd0, o_alu, o_rs1, o_rs2, o_rd}, 32'd0);
      chk({tag, "_strobes"}, {26'd0, o_rs_en, o_alu_en, o_rd_en, o_pc, o_ill, o_done}, 32'd0);
   endtask

   // Drives one instruction and checks it at its COMMIT cycle.
   // alt: ins_valid only on odd cycles. hold is high for cycles [hs, hs+hl);
   // hx is the number of those cycles that fall in EXEC.
   task automatic run(input string tag, input logic sel, input logic [31:0] instr,
                      input bit alt, input int hs, input int hl, input int hx);
      exp_t e, g;
      int lanes, nb, ex, cyc, beat, rdc, rsc;
      bit seen, v, rdy, legal;
      logic [31:0] slice;
      logic [3:0] c_alu;
      logic [4:0] c_rs1, c_rs2, c_rd;
      logic [31:0] c_ins;
      logic c_ill, c_done;

      lanes = sel ? 4 : 1;
      nb    = 32 / lanes;
      ex    = 32 / lanes;
      legal = (instr[6:0] == 7'b0110011) &&
              ((instr[31:25] == 7'd0) ||
               ((instr[31:25] == 7'b0100000) && ((instr[14:12] == 3'd0) || (instr[14:12] == 3'd5))));
      e.ins   = instr;
      e.alu   = {instr[30], instr[14:12]};
      e.rs1   = instr[19:15];
      e.rs2   = instr[24:20];
      e.rd    = instr[11:7];
      e.ill   = !legal;
      e.rsc   = legal ? ex : 0;
      e.rdc   = (legal && instr[11:7] != 5'd0) ? ex : 0;
      e.total = (alt ? 2 * nb : nb) + 1 + (legal ? ex + hx : 0) + 1;
      sb.push_back(e);

      sel_g = sel;
      cyc = 0; beat = 0; rdc = 0; rsc = 0; seen = 0;
      c_alu = '0; c_rs1 = '0; c_rs2 = '0; c_rd = '0; c_ins = '0; c_ill = 0; c_done = 0;
      while (!seen && cyc < 300) begin
         v     = (beat < nb) && (!alt || (cyc % 2 == 1));
         slice = instr >> (beat * lanes);
         if (sel) begin
            d4_valid = v; d4_data = slice[3:0]; d4_hold = (cyc >= hs) && (cyc < hs + hl);
         end else begin
            d1_valid = v; d1_data = slice[0:0]; d1_hold = (cyc >= hs) && (cyc < hs + hl);
         end
         #1;
         rdy = o_ready;
         if (o_rd_en) rdc++;
         if (o_rs_en) rsc++;
         if (o_rs_en !== o_alu_en) chk({tag, "_alu_en"}, {31'd0, o_alu_en}, {31'd0, o_rs_en});
         if (o_pc) begin
            seen = 1;
            c_alu = o_alu; c_rs1 = o_rs1; c_rs2 = o_rs2; c_rd = o_rd;
            c_ins = o_ins; c_ill = o_ill; c_done = o_done;
         end
         @(posedge clk);
         if (v && rdy) beat++;
         @(negedge clk);
         cyc++;
      end
      d1_valid = 0; d1_hold = 0; d4_valid = 0; d4_hold = 0;

      chk({tag, "_commit_seen"}, {31'd0, seen}, 32'd1);
      if (seen) begin
         g = sb.pop_front();
         chk({tag, "_total_cycles"}, cyc, g.total);
         chk({tag, "_insbuffer"}, c_ins, g.ins);
         chk({tag, "_alu_cont"}, {28'd0, c_alu}, {28'd0, g.alu});
         chk({tag, "_regs"}, {17'd0, c_rs1, c_rs2, c_rd}, {17'd0, g.rs1, g.rs2, g.rd});
         chk({tag, "_illegal"}, {31'd0, c_ill}, {31'd0, g.ill});
         chk({tag, "_done"}, {31'd0, c_done}, {31'd0, !g.ill});
         chk({tag, "_rs_en_cycles"}, rsc, g.rsc);
         chk({tag, "_rd_en_cycles"}, rdc, g.rdc);
         #1;
         chk({tag, "_post_idle"}, {29'd0, o_pc, o_busy, o_ready}, 32'd1);
         chk({tag, "_post_fields"}, {17'd0, o_rs1, o_rs2, o_rd}, {17'd0, g.rs1, g.rs2, g.rd});
      end else begin
         void'(sb.pop_front());
      end
   endtask

   initial begin
      logic [31:0] partial;
      repeat (2) @(negedge clk);
      #1;
      sel_g = 1'b1;
      check_reset_state("reset4");
      sel_g = 1'b0;
      check_reset_state("reset1");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // add x1,x2,x3 at LANES=1: 66 cycles, rd_en for 32
      run("add_l1", 1'b0, 32'h003100B3, 1'b0, -10, 0, 0);
      // sub x5,x6,x7 at LANES=4 with valid every other cycle
      run("sub_alt", 1'b1, 32'h407302B3, 1'b1, -10, 0, 0);
      // sra x8,x9,x10 with hold during FETCH (no effect)
      run("sra", 1'b1, mk_r(7'b0100000, 5'd10, 5'd9, 3'b101, 5'd8), 1'b0, 0, 4, 0);
      // illegal funct7=0100000 / funct3=001
      run("ill_f3", 1'b1, mk_r(7'b0100000, 5'd2, 5'd3, 3'b001, 5'd4), 1'b0, -10, 0, 0);
      // addi: wrong opcode
      run("ill_addi", 1'b1, 32'h00000013, 1'b0, -10, 0, 0);
      // add with rd=0
      run("add_rd0", 1'b1, mk_r(7'd0, 5'd5, 5'd6, 3'b000, 5'd0), 1'b0, -10, 0, 0);
      // hold for 3 cycles mid-EXEC (EXEC spans cycles 9..16 without hold)
      run("hold3", 1'b1, mk_r(7'd0, 5'd17, 5'd18, 3'b100, 5'd19), 1'b0, 11, 3, 3);

      // reset mid-FETCH after a few beats
      sel_g = 1'b1;
      partial = mk_r(7'b0100000, 5'd31, 5'd30, 3'b101, 5'd29);
      for (int i = 0; i < 3; i++) begin
         d4_valid = 1'b1;
         d4_data  = partial[4*i +: 4];
         @(posedge clk);
         @(negedge clk);
      end
      d4_valid = 1'b0;
      reset = 1'b0;
      #1;
      check_reset_state("reset_mid");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // fresh instruction after the abort
      run("and_fresh", 1'b1, mk_r(7'd0, 5'd12, 5'd13, 3'b111, 5'd14), 1'b0, -10, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_rtype_ctrl.md
# serial_rtype_ctrl

Parametrised serial control unit for the bit-serial RISC-V datapath. Deserialises a 32-bit instruction arriving LANES bits per cycle under a valid/ready handshake, decodes and legality-checks R-type instructions, then sequences the serial operand/execute phase and the PC update. It replaces the fixed 1-bit, fixed-count sequencer with lane-width and data-width parameters, input back-pressure, illegal-instruction reporting, and execute-phase stalling.

## Interface
- LANES, 1, instruction and operand bits per cycle; legal values 1, 2, 4, 8, 16, 32.
- DATA_W, 32, operand width; must be a multiple of LANES.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ins_data  in  LANES  instruction slice; bit 0 is the lowest-order instruction bit of the beat
- ins_valid  in  1  ins_data valid this cycle
- ins_ready  out  1  unit accepts a beat this cycle
- hold  in  1  freezes EXEC for this cycle
- insbuffer  out  32  assembled instruction
- alu_cont  out  4  {insbuffer[30], insbuffer[14:12]}
- rs1, rs2, rd  out  5 each  register addresses
- rs_en  out  1  operand registers shifting
- alu_en  out  1  serial ALU stepping
- rd_en  out  1  destination write enable
- pcload_en  out  1  one-cycle PC advance strobe
- illegal  out  1  one-cycle illegal-instruction strobe
- done  out  1  one-cycle retire strobe
- busy  out  1  state is not FETCH

## Operation
- States: FETCH, DECODE, EXEC, COMMIT. Reset forces FETCH.
- FETCH: ins_ready = 1. Each cycle with ins_valid = 1 is a beat.
  - On a beat: insbuffer <= {ins_data, insbuffer[31:LANES]}, so the first beat lands in [LANES-1:0] after 32/LANES beats.
  - The beat counter increments only on beats. After beat 32/LANES the counter clears and the state moves to DECODE.
  - Cycles with ins_valid = 0 leave insbuffer and the counter unchanged.
- DECODE, exactly 1 cycle: register alu_cont, rs1 = [19:15], rs2 = [24:20] and rd = [11:7].
  - The instruction is legal when opcode [6:0] = 0110011, funct7 [31:25] ∈ {0000000, 0100000}, and, when funct7 = 0100000, funct3 ∈ {000, 101}.
  - Legal: go to EXEC.
  - Illegal: go to COMMIT with the illegal flag latched. EXEC is skipped and rd_en never rises.
- EXEC: DATA_W/LANES active cycles.
  - While hold = 0: rs_en = alu_en = 1, rd_en = (rd != 0), and the counter increments.
  - While hold = 1: rs_en, alu_en and rd_en are 0 and the counter is frozen.
  - After the last active cycle the state moves to COMMIT.
- COMMIT, exactly 1 cycle: pcload_en = 1.
  - Legal instruction: done = 1.
  - Illegal instruction: illegal = 1 and done = 0.
  - Next state is FETCH. insbuffer is not cleared; it is overwritten by the next fetch.
- Reset (reset low, any state, asynchronous): state = FETCH, counters = 0, insbuffer = 0.
  - alu_cont, rs1, rs2 and rd are 0.
  - rs_en, alu_en, rd_en, pcload_en, illegal, done and busy are all 0.
  - ins_ready is forced to 0 while reset is low.
  - A partially fetched or executing instruction is discarded.

## Timing
- All state, counters and registered outputs update on the rising clk edge. rs_en, alu_en, rd_en, pcload_en, illegal, done, busy and ins_ready are decoded from state/hold.
- Legal instruction with continuous valid and no hold: 32/LANES + 1 + DATA_W/LANES + 1 cycles from first beat to the end of COMMIT.
  - LANES=1, DATA_W=32: 66 cycles.
  - LANES=4: 18 cycles.
- Illegal instruction: 32/LANES + 2 cycles.
- The next instruction's first beat can be accepted on the cycle after COMMIT. There are no bubbles beyond that.
- Each hold cycle in EXEC adds exactly one cycle of latency. hold outside EXEC has no effect.
- alu_cont, rs1, rs2 and rd become valid the cycle after DECODE and stay stable through COMMIT and the following FETCH, until the next DECODE.

## Test plan
- add x1,x2,x3 (0x003100B3), LANES=1, DATA_W=32, valid always 1:
  - alu_cont=0000, rs1=2, rs2=3, rd=1.
  - rd_en high for 32 cycles.
  - pcload_en and done on cycle 66.
- sub x5,x6,x7 (0x407302B3) at LANES=4, with ins_valid low every other cycle:
  - 8 beats over 16 cycles.
  - alu_cont=1000.
  - EXEC lasts 8 cycles.
- sra with funct7=0100000, funct3=101: alu_cont=1101, legal.
- Illegal encodings, each giving an illegal pulse with pcload_en, no rd_en, and done=0:
  - funct7=0100000 with funct3=001.
  - 0x00000013 (addi).
- add with rd=0: rd_en stays 0 throughout EXEC, and done still pulses.
- Interference cases:
  - hold high for 3 cycles mid-EXEC: EXEC lasts DATA_W/LANES+3 cycles.
  - reset low mid-FETCH: all outputs 0.
  - After release, a fresh instruction decodes correctly with no residue from the aborted one.
